// File: rtl/kernel_pkg.sv
// Shared constants and types for the 3x3 kernel window generator.
package kernel_pkg;

   localparam int KERNEL_SIZE  = 3;
   localparam int WINDOW_ELEMS = KERNEL_SIZE * KERNEL_SIZE;

   typedef enum logic {
      STRIDE_1 = 1'b0,
      STRIDE_2 = 1'b1
   } stride_e;

   // Output grid dimension for one image axis; trailing partial windows are dropped.
   function automatic int out_dim(input int img_dim, input stride_e stride);
      return (img_dim - KERNEL_SIZE) / ((stride == STRIDE_2) ? 2 : 1) + 1;
   endfunction

endpackage

// File: rtl/kernel_window_3x3_gen_if.sv
// Pixel stream in, packed window plus output-grid indices out.
interface kernel_window_3x3_gen_if
   import kernel_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int COORD_W    = 9
);

   logic [DATA_WIDTH-1:0]              Data_In;
   logic                               Valid_in;
   logic                               Frame_Start;
   logic                               Stride_Sel;
   logic [WINDOW_ELEMS*DATA_WIDTH-1:0] Window_Out;
   logic                               Valid_Out;
   logic [COORD_W-1:0]                 Out_Row;
   logic [COORD_W-1:0]                 Out_Col;
   logic                               Frame_Done;

   modport master (
      output Data_In, Valid_in, Frame_Start, Stride_Sel,
      input  Window_Out, Valid_Out, Out_Row, Out_Col, Frame_Done
   );

   modport slave (
      input  Data_In, Valid_in, Frame_Start, Stride_Sel,
      output Window_Out, Valid_Out, Out_Row, Out_Col, Frame_Done
   );

endinterface

// File: rtl/kernel_window_3x3_gen_line_buffer.sv
// Circular row delay: rd_data always holds the pixel written DEPTH enables
// before the next one, so it lines up with the next accepted pixel.
module line_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 299
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      nxt_ptr;

   assign nxt_ptr = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;

   always_ff @(posedge clk) begin
      if (en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Read ahead the slot that the next enable overwrites, i.e. its old contents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_data <= '0;
      end else if (en) begin
         wr_ptr  <= nxt_ptr;
         rd_data <= mem[nxt_ptr];
      end
   end

endmodule

// File: rtl/kernel_window_3x3_gen.sv
// Raster pixel stream to 3x3 windows at stride 1 or 2, with output-grid
// indices and an end-of-frame pulse.
module kernel_window_3x3_gen
   import kernel_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 299,
   parameter int IMG_HEIGHT = 299,
   parameter int COORD_W    = 9
) (
   input logic                    clk,
   input logic                    rst,
   kernel_window_3x3_gen_if.slave bus
);

   localparam logic [COORD_W-1:0] LAST_COL  = COORD_W'(IMG_WIDTH - 1);
   localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(IMG_HEIGHT - 1);
   localparam logic [COORD_W-1:0] FIRST_OUT = COORD_W'(KERNEL_SIZE - 1);
   localparam logic [COORD_W-1:0] CNT_ONE   = COORD_W'(1);
   localparam int                 HIST_N    = KERNEL_SIZE * (KERNEL_SIZE - 1);

   logic [DATA_WIDTH-1:0] row1_pix;
   logic [DATA_WIDTH-1:0] row2_pix;

   logic [COORD_W-1:0] col_q, row_q, oc_q, or_q;
   logic [COORD_W-1:0] eff_col, eff_row, oc_base, or_base;
   stride_e            stride_q, stride_eff;
   logic               row_end, frame_end, col_hit, row_hit, win_hit;

   logic [DATA_WIDTH-1:0]              hist [HIST_N];
   logic [DATA_WIDTH-1:0]              win_elems [WINDOW_ELEMS];
   logic [WINDOW_ELEMS*DATA_WIDTH-1:0] win_packed;

   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_row1 (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.Valid_in),
      .wr_data (bus.Data_In),
      .rd_data (row1_pix)
   );

   line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_row2 (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.Valid_in),
      .wr_data (row1_pix),
      .rd_data (row2_pix)
   );

   // Frame_Start forces the current pixel to (0,0) and restarts the output grid.
   always_comb begin
      eff_col    = col_q;
      eff_row    = row_q;
      oc_base    = oc_q;
      or_base    = or_q;
      stride_eff = stride_q;
      if (bus.Frame_Start) begin
         eff_col = '0;
         eff_row = '0;
         oc_base = '0;
         or_base = '0;
      end
      if (eff_col == '0 && eff_row == '0) begin
         stride_eff = stride_e'(bus.Stride_Sel);
      end
      row_end   = (eff_col == LAST_COL);
      frame_end = row_end && (eff_row == LAST_ROW);
      col_hit   = (eff_col >= FIRST_OUT) && ((stride_eff == STRIDE_1) || !eff_col[0]);
      row_hit   = (eff_row >= FIRST_OUT) && ((stride_eff == STRIDE_1) || !eff_row[0]);
      win_hit   = col_hit && row_hit;
   end

   // Two held columns plus the live column from the line buffers form the window.
   always_comb begin
      win_elems  = '{hist[0], hist[1], row2_pix,
                     hist[2], hist[3], row1_pix,
                     hist[4], hist[5], bus.Data_In};
      win_packed = '0;
      for (int k = 0; k < WINDOW_ELEMS; k++) begin
         win_packed[k*DATA_WIDTH +: DATA_WIDTH] = win_elems[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q    <= '0;
         row_q    <= '0;
         oc_q     <= '0;
         or_q     <= '0;
         stride_q <= STRIDE_1;
      end else if (bus.Valid_in) begin
         stride_q <= stride_eff;
         col_q    <= row_end ? '0 : eff_col + CNT_ONE;
         if (frame_end) begin
            row_q <= '0;
         end else if (row_end) begin
            row_q <= eff_row + CNT_ONE;
         end else begin
            row_q <= eff_row;
         end
         if (row_end) begin
            oc_q <= '0;
         end else if (win_hit) begin
            oc_q <= oc_base + CNT_ONE;
         end else begin
            oc_q <= oc_base;
         end
         if (frame_end) begin
            or_q <= '0;
         end else if (row_end && row_hit) begin
            or_q <= or_base + CNT_ONE;
         end else begin
            or_q <= or_base;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '{default: '0};
      end else if (bus.Valid_in) begin
         hist[0] <= hist[1];
         hist[1] <= row2_pix;
         hist[2] <= hist[3];
         hist[3] <= row1_pix;
         hist[4] <= hist[5];
         hist[5] <= bus.Data_In;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.Window_Out <= '0;
         bus.Out_Row    <= '0;
         bus.Out_Col    <= '0;
         bus.Valid_Out  <= 1'b0;
         bus.Frame_Done <= 1'b0;
      end else begin
         bus.Valid_Out  <= bus.Valid_in && win_hit;
         bus.Frame_Done <= bus.Valid_in && frame_end;
         if (bus.Valid_in && win_hit) begin
            bus.Window_Out <= win_packed;
            bus.Out_Row    <= or_base;
            bus.Out_Col    <= oc_base;
         end
      end
   end

endmodule

// File: tb/tb_kernel_window_3x3_gen.sv
// Scoreboard bench for kernel_window_3x3_gen on an 8x6 ramp image (pixel = r*8+c).
module tb_kernel_window_3x3_gen;
   import kernel_pkg::*;

   localparam int DW    = 8;
   localparam int W     = 8;
   localparam int H     = 6;
   localparam int CW    = 9;
   localparam int WIN_W = 9 * DW;

   typedef struct {
      logic [WIN_W-1:0] win;
      int               row;
      int               col;
      int               cyc;
   } win_t;

   typedef int arr9_t [9];

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   win_t exp_q [$];
   int   done_q [$];
   win_t obs_q [$];
   win_t ref_s1 [$];
   win_t ref_s2 [$];
   int   vout_cnt, done_cnt, last_vout_cyc, last_done_cyc;

   int   m_r, m_c;
   logic m_s2;
   win_t mon_cur, mon_exp;

   kernel_window_3x3_gen_if #(.DATA_WIDTH(DW), .COORD_W(CW)) bus ();

   kernel_window_3x3_gen #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .COORD_W    (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [WIN_W-1:0] pack9(input arr9_t e);
      logic [WIN_W-1:0] p;
      p = '0;
      for (int k = 0; k < 9; k++) p[k*DW +: DW] = DW'(e[k]);
      return p;
   endfunction

   // Window whose bottom-right pixel is (r,c) of the ramp image.
   function automatic logic [WIN_W-1:0] model_window(input int r, input int c);
      arr9_t e;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            e[i*3+j] = (r - 2 + i) * W + (c - 2 + j);
      return pack9(e);
   endfunction

   function automatic win_t get_obs(input int i);
      win_t d;
      d.win = '0;
      d.row = -1;
      d.col = -1;
      d.cyc = -1;
      if (i >= 0 && i < obs_q.size()) d = obs_q[i];
      return d;
   endfunction

   task automatic check_output(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Drive one accepted pixel and push whatever the model says it completes.
   task automatic apply_stimulus(input logic fs, input logic ssel);
      int   s;
      win_t e;
      if (fs) begin
         m_r = 0;
         m_c = 0;
      end
      if (m_r == 0 && m_c == 0) m_s2 = ssel;
      s = m_s2 ? 2 : 1;
      @(negedge clk);
      bus.Data_In     = DW'(m_r * W + m_c);
      bus.Valid_in    = 1'b1;
      bus.Frame_Start = fs;
      bus.Stride_Sel  = ssel;
      if (m_r >= 2 && m_c >= 2 && (m_r - 2) % s == 0 && (m_c - 2) % s == 0) begin
         e.win = model_window(m_r, m_c);
         e.row = (m_r - 2) / s;
         e.col = (m_c - 2) / s;
         e.cyc = cyc + 1;
         exp_q.push_back(e);
      end
      if (m_r == H - 1 && m_c == W - 1) done_q.push_back(cyc + 1);
      if (m_c == W - 1) begin
         m_c = 0;
         m_r = (m_r == H - 1) ? 0 : m_r + 1;
      end else begin
         m_c++;
      end
   endtask

   // Gap cycles carry junk data and a stray Frame_Start, all of which must be ignored.
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.Valid_in    = 1'b0;
         bus.Frame_Start = 1'b1;
         bus.Data_In     = 8'hA5;
         bus.Stride_Sel  = ~bus.Stride_Sel;
      end
   endtask

   task automatic send_frame(input logic fs_first, input logic ssel, input int max_gap);
      for (int i = 0; i < W * H; i++) begin
         apply_stimulus(fs_first && (i == 0), ssel);
         if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      end
   endtask

   task automatic new_section();
      obs_q.delete();
      vout_cnt      = 0;
      done_cnt      = 0;
      last_vout_cyc = -1;
      last_done_cyc = -2;
   endtask

   task automatic check_against(input string name, input win_t ref_q [$]);
      win_t o;
      for (int i = 0; i < ref_q.size(); i++) begin
         o = get_obs(i);
         check_output({name, " window"}, o.win, ref_q[i].win);
         check_int({name, " Out_Row"}, o.row, ref_q[i].row);
         check_int({name, " Out_Col"}, o.col, ref_q[i].col);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check_int({tag, " Valid_Out"}, int'(bus.Valid_Out), 0);
      check_int({tag, " Frame_Done"}, int'(bus.Frame_Done), 0);
      check_output({tag, " Window_Out"}, bus.Window_Out, '0);
      check_int({tag, " Out_Row"}, int'(bus.Out_Row), 0);
      check_int({tag, " Out_Col"}, int'(bus.Out_Col), 0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (bus.Valid_Out) begin
            mon_cur.win = bus.Window_Out;
            mon_cur.row = int'(bus.Out_Row);
            mon_cur.col = int'(bus.Out_Col);
            mon_cur.cyc = cyc;
            obs_q.push_back(mon_cur);
            vout_cnt++;
            last_vout_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("[TB] FAIL window unexpected: got win=%0h row=%0d col=%0d cyc=%0d, want none",
                        mon_cur.win, mon_cur.row, mon_cur.col, cyc);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_cur.win !== mon_exp.win || mon_cur.row != mon_exp.row ||
                   mon_cur.col != mon_exp.col || mon_cur.cyc != mon_exp.cyc) begin
                  n_err++;
                  $display("[TB] FAIL window: got win=%0h row=%0d col=%0d cyc=%0d, want win=%0h row=%0d col=%0d cyc=%0d",
                           mon_cur.win, mon_cur.row, mon_cur.col, mon_cur.cyc,
                           mon_exp.win, mon_exp.row, mon_exp.col, mon_exp.cyc);
               end
            end
         end
         if (bus.Frame_Done) begin
            done_cnt++;
            last_done_cyc = cyc;
            n_cmp++;
            if (done_q.size() == 0) begin
               n_err++;
               $display("[TB] FAIL frame_done unexpected: got pulse at cyc=%0d, want none", cyc);
            end else if (done_q[0] != cyc) begin
               n_err++;
               $display("[TB] FAIL frame_done: got cyc=%0d, want cyc=%0d", cyc, done_q[0]);
               void'(done_q.pop_front());
            end else begin
               void'(done_q.pop_front());
            end
         end
      end
   end

   initial begin
      win_t o;
      int   max_col;
      rst             = 1'b1;
      bus.Data_In     = '0;
      bus.Valid_in    = 1'b0;
      bus.Frame_Start = 1'b0;
      bus.Stride_Sel  = 1'b0;
      m_r  = 0;
      m_c  = 0;
      m_s2 = 1'b0;
      new_section();
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b1;

      $display("[TB] stride 1 frame");
      new_section();
      send_frame(1'b1, 1'b0, 0);
      idle(4);
      check_int("s1 window count", vout_cnt, 24);
      check_int("s1 frame_done count", done_cnt, 1);
      o = get_obs(0);
      check_output("s1 first window", o.win, pack9('{0, 1, 2, 8, 9, 10, 16, 17, 18}));
      check_int("s1 first Out_Row", o.row, 0);
      check_int("s1 first Out_Col", o.col, 0);
      o = get_obs(23);
      check_output("s1 last window", o.win, pack9('{29, 30, 31, 37, 38, 39, 45, 46, 47}));
      check_int("s1 last Out_Row", o.row, 3);
      check_int("s1 last Out_Col", o.col, 5);
      check_int("s1 frame_done with last window", last_done_cyc, last_vout_cyc);
      ref_s1 = obs_q;

      $display("[TB] stride 2 frame");
      new_section();
      send_frame(1'b1, 1'b1, 0);
      idle(4);
      check_int("s2 window count", vout_cnt, 6);
      o = get_obs(1);
      check_output("s2 second window", o.win, pack9('{2, 3, 4, 10, 11, 12, 18, 19, 20}));
      check_int("s2 second Out_Row", o.row, 0);
      check_int("s2 second Out_Col", o.col, 1);
      max_col = -1;
      foreach (obs_q[i]) if (obs_q[i].col > max_col) max_col = obs_q[i].col;
      check_int("s2 max Out_Col", max_col, 2);
      ref_s2 = obs_q;

      $display("[TB] stride 2 frame with gaps");
      new_section();
      send_frame(1'b1, 1'b1, 3);
      idle(4);
      check_int("gap window count", vout_cnt, 6);
      check_against("gap vs gap-free", ref_s2);

      $display("[TB] mid-frame stride toggle, back-to-back frames");
      new_section();
      for (int i = 0; i < W * H; i++) apply_stimulus(i == 0, i >= 10);
      for (int i = 0; i < W * H; i++) apply_stimulus(1'b0, 1'b1);
      idle(4);
      check_int("b2b window count", vout_cnt, 30);
      check_int("b2b frame_done count", done_cnt, 2);

      $display("[TB] resync on pixel 20");
      new_section();
      for (int i = 0; i < 20; i++) apply_stimulus(i == 0, 1'b0);
      send_frame(1'b1, 1'b0, 0);
      idle(4);
      check_int("resync window count", vout_cnt, 26);
      check_int("resync frame_done count", done_cnt, 1);
      o = get_obs(2);
      check_output("resync first window", o.win, pack9('{0, 1, 2, 8, 9, 10, 16, 17, 18}));
      check_int("resync first Out_Col", o.col, 0);

      $display("[TB] reset at pixel 30");
      new_section();
      for (int i = 0; i < 30; i++) apply_stimulus(i == 0, 1'b0);
      @(negedge clk);
      bus.Data_In     = DW'(30);
      bus.Valid_in    = 1'b1;
      bus.Frame_Start = 1'b0;
      #2 rst = 1'b0;
      #1 check_zero_outputs("mid-frame reset");
      check_int("pending windows at reset", exp_q.size(), 0);
      m_r = 0;
      m_c = 0;
      idle(2);
      rst = 1'b1;
      new_section();
      send_frame(1'b0, 1'b0, 0);
      idle(4);
      check_int("post-reset window count", vout_cnt, 24);
      check_int("post-reset frame_done count", done_cnt, 1);
      check_against("post-reset vs s1", ref_s1);

      check_int("leftover expected windows", exp_q.size(), 0);
      check_int("leftover expected frame_done", done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
